// File: rtl/tpu_pkg.sv
// ============================================================================
// tpu_pkg : shared TPU types, SYNCH barrier state encoding and unit count
// Rev 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

    typedef logic [31:0] word_type;

    typedef enum logic [1:0] {
        SYNCH_IDLE  = 2'd0,
        SYNCH_DRAIN = 2'd1,
        SYNCH_FIRE  = 2'd2
    } synch_state_type;

    localparam int SYNCH_UNITS = 3;

endpackage

`default_nettype wire

// File: rtl/synch_gen_outstanding_ctr.sv
// ============================================================================
// outstanding_ctr : per-unit outstanding instruction counter with status flags
// Rev 1.0
// ============================================================================
`default_nettype none

module outstanding_ctr
    import tpu_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 zero,
    output logic                 full,
    output logic                 underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    assign zero      = (cnt == '0);
    assign full      = (cnt == CNT_MAX);
    assign underflow = dec && zero;

    // A completion against an empty counter is reported but never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/synch_gen.sv
// ============================================================================
// synch_gen : stalls issue after SYNCH until all units drain, then pulses synch
// Rev 1.0
// ============================================================================
`default_nettype none

module synch_gen
    import tpu_pkg::*;
#(
    parameter int NUM_UNITS = SYNCH_UNITS,
    parameter int CNT_WIDTH = 4,
    parameter int TIMEOUT   = 2**20,
    localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_en,
    input  logic                 instr_is_synch,
    input  logic [UNIT_W-1:0]    instr_unit,
    output logic                 instr_ready,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic [NUM_UNITS-1:0] unit_busy,
    output logic                 synch,
    output logic                 synch_pending,
    output logic                 timeout,
    output logic                 underflow_err,
    output word_type             drain_cycles
);

    localparam int       UNIT_SPAN   = 1 << UNIT_W;
    localparam word_type TIMEOUT_LIM = word_type'(TIMEOUT - 1);
    localparam word_type TIMER_MAX   = '1;

    synch_state_type state;
    synch_state_type state_next;

    logic [NUM_UNITS-1:0] inc;
    logic [NUM_UNITS-1:0] zero;
    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] underflow;
    logic [UNIT_SPAN-1:0] full_ext;
    logic [UNIT_SPAN-1:0] done_ext;
    logic                 target_full;
    logic                 accept_work;
    logic                 accept_synch;
    logic                 all_idle;
    word_type             timer;

    // Out-of-range unit indices land on zero padding: never full, never counted.
    assign full_ext    = UNIT_SPAN'(full);
    assign done_ext    = UNIT_SPAN'(unit_done);
    assign target_full = full_ext[instr_unit] && !done_ext[instr_unit];

    assign accept_work  = instr_en && instr_ready && !instr_is_synch;
    assign accept_synch = instr_en && instr_ready && instr_is_synch;
    assign all_idle     = (&zero) && (unit_busy == '0) && (unit_done == '0);

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        logic [CNT_WIDTH-1:0] cnt_unused;

        assign inc[u] = accept_work && (instr_unit == UNIT_W'(u));

        outstanding_ctr #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ctr (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[u]),
            .dec       (unit_done[u]),
            .cnt       (cnt_unused),
            .zero      (zero[u]),
            .full      (full[u]),
            .underflow (underflow[u])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SYNCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        instr_ready   = 1'b0;
        synch_pending = 1'b0;
        case (state)
            SYNCH_IDLE: begin
                instr_ready = rst && !(!instr_is_synch && target_full);
                if (accept_synch) begin
                    state_next = SYNCH_DRAIN;
                end
            end
            SYNCH_DRAIN: begin
                synch_pending = 1'b1;
                if (all_idle) begin
                    state_next = SYNCH_FIRE;
                end
            end
            SYNCH_FIRE: begin
                state_next = SYNCH_IDLE;
            end
            default: begin
                state_next = SYNCH_IDLE;
            end
        endcase
    end

    // Timer starts at 1 on the accepting cycle, so drain_cycles spans accept..fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer         <= '0;
            synch         <= 1'b0;
            timeout       <= 1'b0;
            underflow_err <= 1'b0;
            drain_cycles  <= '0;
        end else begin
            synch         <= (state == SYNCH_DRAIN) && all_idle;
            underflow_err <= underflow_err | (|underflow);
            if (accept_synch) begin
                timer <= word_type'(1);
            end else if (state == SYNCH_DRAIN && timer != TIMER_MAX) begin
                timer <= timer + 1'b1;
            end
            if (state == SYNCH_DRAIN && timer >= TIMEOUT_LIM) begin
                timeout <= 1'b1;
            end
            if (state == SYNCH_FIRE) begin
                drain_cycles <= timer;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_synch_gen.sv
// ============================================================================
// tb_synch_gen : directed + random stimulus against a timestamp-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_synch_gen;
    import tpu_pkg::*;

    localparam int NU = 3;
    localparam int CW = 4;
    localparam int TO = 20;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_en;
    logic          instr_is_synch;
    logic [1:0]    instr_unit;
    logic          instr_ready;
    logic [NU-1:0] unit_done;
    logic [NU-1:0] unit_busy;
    logic          synch;
    logic          synch_pending;
    logic          timeout;
    logic          underflow_err;
    word_type      drain_cycles;

    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       cnt_m [NU];
    int       acc_cyc;
    int       fire_cyc;
    bit       to_m;
    bit       uf_m;
    bit       ready_m;
    word_type drain_m;
    int       seen;

    always #5 clk = ~clk;

    synch_gen #(
        .NUM_UNITS (NU),
        .CNT_WIDTH (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_en       (instr_en),
        .instr_is_synch (instr_is_synch),
        .instr_unit     (instr_unit),
        .instr_ready    (instr_ready),
        .unit_done      (unit_done),
        .unit_busy      (unit_busy),
        .synch          (synch),
        .synch_pending  (synch_pending),
        .timeout        (timeout),
        .underflow_err  (underflow_err),
        .drain_cycles   (drain_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void reset_model();
        for (int u = 0; u < NU; u++) cnt_m[u] = 0;
        acc_cyc  = -1;
        fire_cyc = -1;
        to_m     = 1'b0;
        uf_m     = 1'b0;
        drain_m  = '0;
    endfunction

    function automatic bit exp_ready();
        if (!rst) return 1'b0;
        if (acc_cyc >= 0) return 1'b0;
        if (instr_is_synch || int'(instr_unit) >= NU) return 1'b1;
        return !(cnt_m[instr_unit] == CMAX && !unit_done[instr_unit]);
    endfunction

    // One clock cycle: check outputs against the model, advance the model, clock.
    task automatic tick();
        bit idle;
        bit draining;
        bit inc;
        #2;
        ready_m = exp_ready();
        chk("instr_ready", instr_ready, ready_m);
        if (rst) begin
            chk("synch", synch, cyc == fire_cyc);
            chk("synch_pending", synch_pending,
                acc_cyc >= 0 && cyc > acc_cyc && (fire_cyc < 0 || cyc < fire_cyc));
            chk("timeout", timeout, to_m);
            chk("underflow_err", underflow_err, uf_m);
            chk("drain_cycles", drain_cycles, drain_m);

            idle = (unit_busy == '0) && (unit_done == '0);
            for (int u = 0; u < NU; u++) if (cnt_m[u] != 0) idle = 1'b0;
            draining = acc_cyc >= 0 && cyc > acc_cyc && fire_cyc < 0;
            if (draining && (cyc - acc_cyc) >= TO - 1) to_m = 1'b1;
            if (draining && idle) fire_cyc = cyc + 1;
            if (cyc == fire_cyc) begin
                drain_m  = word_type'(fire_cyc - acc_cyc);
                acc_cyc  = -1;
                fire_cyc = -1;
            end
            if (ready_m && instr_en && instr_is_synch) acc_cyc = cyc;
            for (int u = 0; u < NU; u++) begin
                inc = ready_m && instr_en && !instr_is_synch && int'(instr_unit) == u;
                if (unit_done[u] && cnt_m[u] == 0) uf_m = 1'b1;
                if (inc && !unit_done[u]) cnt_m[u]++;
                else if (unit_done[u] && !inc && cnt_m[u] > 0) cnt_m[u]--;
            end
        end else begin
            reset_model();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        instr_en       = 1'b0;
        instr_is_synch = 1'b0;
        instr_unit     = '0;
        unit_done      = '0;
        unit_busy      = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        reset_model();
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst = 1'b1;

        // SYNCH with nothing outstanding
        instr_en = 1'b1; instr_is_synch = 1'b1;
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("t1_drain_cycles", drain_cycles, 2);

        // three instructions to unit 1, SYNCH, completions at +5/+9/+14
        for (int i = 0; i < 3; i++) begin
            instr_en = 1'b1; instr_unit = 2'd1;
            tick();
        end
        instr_is_synch = 1'b1;
        tick();
        idle_inputs();
        for (int k = 1; k <= 18; k++) begin
            unit_done = (k == 5 || k == 9 || k == 14) ? 3'b010 : 3'b000;
            tick();
        end
        chk("t2_drain_cycles", drain_cycles, 16);

        // fill unit 0, then the 16th stalls unless a done arrives with it
        for (int i = 0; i < CMAX; i++) begin
            instr_en = 1'b1; instr_unit = 2'd0;
            tick();
        end
        tick();
        unit_done = 3'b001;
        tick();
        unit_done = 3'b000;
        tick();
        chk("t3_still_full", instr_ready, 0);
        idle_inputs();
        for (int i = 0; i < CMAX; i++) begin
            unit_done = 3'b001;
            tick();
        end
        unit_done = '0;

        // completion on an empty unit
        unit_done = 3'b100;
        tick();
        unit_done = '0;
        repeat (3) tick();
        chk("t4_underflow_sticky", underflow_err, 1);

        // random traffic including out-of-range units and random busy
        for (int i = 0; i < 300; i++) begin
            instr_en       = ($urandom_range(0, 1) == 1);
            instr_is_synch = ($urandom_range(0, 11) == 0);
            instr_unit     = 2'($urandom_range(0, 3));
            unit_busy      = 3'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7));
            for (int u = 0; u < NU; u++)
                unit_done[u] = (cnt_m[u] > 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_inputs();
        for (int u = 0; u < NU; u++) begin
            while (cnt_m[u] > 0) begin
                unit_done = '0;
                unit_done[u] = 1'b1;
                tick();
            end
        end
        idle_inputs();
        repeat (4) tick();

        // timeout while a unit stays busy
        rst = 1'b0;
        tick();
        rst = 1'b1;
        instr_en = 1'b1; instr_is_synch = 1'b1;
        tick();
        idle_inputs();
        unit_busy = 3'b001;
        repeat (TO + 5) tick();
        chk("t5_timeout", timeout, 1);
        unit_busy = '0;
        repeat (3) tick();
        chk("t5_drain_cycles", drain_cycles, TO + 7);

        // reset in the middle of a drain discards the pending synch
        instr_en = 1'b1; instr_unit = 2'd2;
        tick();
        instr_is_synch = 1'b1;
        tick();
        idle_inputs();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (synch) seen++;
            tick();
        end
        chk("t6_no_synch", seen, 0);
        chk("t6_timeout_clear", timeout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
